// File: rtl/instruction_issue_queue_pkg.sv
// Shared definitions for the instruction issue queue and the control circuit.
// Instruction format: {opcode[10:8], Rx[7:4], Ry[3:0]}.
package instruction_issue_queue_pkg;

    localparam int OPCODE_W   = 3;
    localparam int OPERAND_W  = 8;
    localparam int HOLD_CNT_W = 3;

    localparam logic [OPCODE_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b011;

    // Opcode 111 sends the control FSM into its default branch, so it stays in its initial state.
    localparam logic [OPCODE_W+OPERAND_W-1:0] IDLE_INSTR = 11'b111_0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_t;

    // Cycles an instruction stays on the bus, including the control FSM's initial state.
    function automatic logic [HOLD_CNT_W-1:0] hold_len(input logic [OPCODE_W-1:0] opcode);
        logic [HOLD_CNT_W-1:0] len;
        case (opcode)
            OP_LOAD:        len = 3'd3;
            OP_MOV:         len = 3'd2;
            OP_ADD, OP_SUB: len = 3'd4;
            default:        len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instruction_issue_queue_instr_fifo.sv
// instr_fifo: synchronous circular buffer with wrapping read/write pointers
// and an occupancy counter. Push is ignored when full, pop when empty.
module instr_fifo
    import instruction_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic [PTR_W-1:0] wr_ptr_nx_s;
    logic [PTR_W-1:0] rd_ptr_nx_s;
    logic [CNT_W-1:0] count_nx_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && !empty_s;

    // Next pointer and occupancy values; pointers wrap from DEPTH-1 back to 0.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        count_nx_s  = count_r;
        if (do_push_s) begin
            wr_ptr_nx_s = (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_nx_s = (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Pointer and occupancy state; flushed by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
        end
    end

    // Storage array; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/instruction_issue_queue.sv
// instruction_issue_queue: buffers host instructions and presents them one at
// a time on INSTRUCTION, holding each for the control FSM's execution length.
// Optional macro ISSUE_COUNT_EN adds a 16-bit wrapping issue_count output.
module instruction_issue_queue
    import instruction_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [INSTR_W-1:0]     wr_instr,
    output logic                   wr_ready,
    output logic [INSTR_W-1:0]     INSTRUCTION,
    output logic                   issue,
    output logic                   busy,
    output logic                   empty,
`ifdef ISSUE_COUNT_EN
    output logic [15:0]            issue_count,
`endif
    output logic [$clog2(DEPTH):0] count
);

    logic [INSTR_W-1:0]    fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;

    issue_state_t          state_r;
    issue_state_t          state_nx_s;
    logic [HOLD_CNT_W-1:0] hold_cnt_r;
    logic [HOLD_CNT_W-1:0] hold_cnt_nx_s;
    logic [INSTR_W-1:0]    instr_r;
    logic [INSTR_W-1:0]    instr_nx_s;
    logic                  issue_r;
    logic                  issue_nx_s;
    logic                  busy_r;
    logic                  window_done_s;
    logic [HOLD_CNT_W-1:0] head_len_s;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_valid),
        .pop   (pop_s),
        .din   (wr_instr),
        .head  (fifo_head_s),
        .count (count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_len_s    = hold_len(fifo_head_s[INSTR_W-1 -: OPCODE_W]);
    assign window_done_s = (state_r == ST_IDLE) || (hold_cnt_r == {HOLD_CNT_W{1'b0}});

    // Issue FSM next state: load the head when the current window ends, otherwise count down.
    always_comb begin
        state_nx_s    = state_r;
        hold_cnt_nx_s = hold_cnt_r;
        instr_nx_s    = instr_r;
        issue_nx_s    = 1'b0;
        pop_s         = 1'b0;
        if (window_done_s && !fifo_empty_s) begin
            pop_s         = 1'b1;
            state_nx_s    = ST_HOLD;
            instr_nx_s    = fifo_head_s;
            hold_cnt_nx_s = head_len_s - 3'd1;
            issue_nx_s    = 1'b1;
        end else if (window_done_s) begin
            state_nx_s    = ST_IDLE;
            instr_nx_s    = INSTR_W'(IDLE_INSTR);
            hold_cnt_nx_s = {HOLD_CNT_W{1'b0}};
        end else begin
            hold_cnt_nx_s = hold_cnt_r - 3'd1;
        end
    end

    // Issue FSM state and registered outputs; reset drops INSTRUCTION to idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HOLD_CNT_W{1'b0}};
            instr_r    <= INSTR_W'(IDLE_INSTR);
            issue_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            hold_cnt_r <= hold_cnt_nx_s;
            instr_r    <= instr_nx_s;
            issue_r    <= issue_nx_s;
            busy_r     <= (state_nx_s == ST_HOLD);
        end
    end

`ifdef ISSUE_COUNT_EN
    logic [15:0] issue_count_r;

    // Total issued instructions, wrapping from 0xFFFF to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_count_r <= 16'd0;
        end else if (issue_nx_s) begin
            issue_count_r <= issue_count_r + 16'd1;
        end else begin
            issue_count_r <= issue_count_r;
        end
    end

    assign issue_count = issue_count_r;
`endif

    assign wr_ready    = !fifo_full_s;
    assign empty       = fifo_empty_s;
    assign INSTRUCTION = instr_r;
    assign issue       = issue_r;
    assign busy        = busy_r;

endmodule
